mux_scan_serializer: RTL
========================

Name: mux_scan_serializer

Overview:
- Upstream sequencer for the 16:1 bit-select mux.
- Accepts 16-bit words on a valid/ready handshake and holds each word on the mux data inputs.
- Steps the 4-bit mux select through all 16 positions and forwards the mux output as a framed serial bitstream with valid/ready flow control.
- The mux stays a separate, purely combinational instance between mux_d/mux_s and mux_y.

Parameters:
- LSB_FIRST, 1: select order. 1 = select 0 up to 15; 0 = select 15 down to 0.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream word valid.
- in_data  input  16  upstream word.
- in_ready  output  1  block can accept a word this cycle.
- mux_d  output  16  registered word, drives the mux data inputs.
- mux_s  output  4  registered select, drives the mux select.
- mux_y  input  1  combinational mux output (equals mux_d[mux_s]).
- out_valid  output  1  serial beat valid.
- out_bit  output  1  serial data bit.
- out_first  output  1  first beat of the frame.
- out_last  output  1  final beat of the frame.
- out_ready  input  1  downstream accepts the beat.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset values: state IDLE; mux_d = 0; mux_s = 0; out_valid, out_first and out_last = 0; parity accumulator = 0. in_ready = 1 once rst deasserts.
- States: IDLE and SHIFT, plus PAR when the optional feature is compiled in.
- IDLE:
  - in_ready = 1 and out_valid = 0.
  - On in_valid: mux_d <= in_data; mux_s <= start index (0 if LSB_FIRST, else 15); go to SHIFT.
- SHIFT:
  - out_valid = 1.
  - out_bit = mux_y, with a combinational path from mux_y to out_bit (zero added latency).
  - out_first = 1 when mux_s == start index.
  - out_last = 1 when mux_s == end index (15 if LSB_FIRST, else 0) and PAR is not compiled in.
  - On out_ready with mux_s != end index: mux_s steps +1 (LSB_FIRST) or -1.
  - On out_ready with mux_s == end index, without the parity feature:
    - in_ready = 1 combinationally in this cycle.
    - If in_valid is also high: reload mux_d and mux_s and stay in SHIFT. This gives back-to-back frames with zero bubble, one beat per cycle.
    - Otherwise go to IDLE.
- Stall: out_ready = 0 holds mux_d, mux_s and all out_* signals stable, and in_ready = 0.
- Latency: word accepted at cycle N; first beat presented at cycle N+1; a full frame needs 16 accepted beats.
- in_ready is 0 in SHIFT except on the end-index accepted beat.
- out_bit = 0 when out_valid = 0.
- mux_s never leaves 0..15 and never wraps; the step at the end index is replaced by the reload or hold.
- mux_d is only written on an accepted in_valid handshake.
- Reset mid-frame: the frame is abandoned immediately and no further beats are emitted; the upstream word in flight is dropped.

Optional Feature:
- Macro: MUX_SCAN_PARITY_EN.
- With the macro:
  - Parity accumulator p is cleared on each word load and XORs out_bit on every accepted SHIFT beat.
  - After the end-index beat, go to PAR instead of IDLE.
  - In PAR: out_valid = 1, out_bit = p (even parity over the 16 bits), out_last = 1, out_first = 0; mux_s holds.
  - On out_ready in PAR: in_ready = 1. Reload and go to SHIFT if in_valid is high, else go to IDLE.
  - Frame = 17 beats; out_last is never set in SHIFT.
- Without the macro: no PAR state and no accumulator; 16-beat frames as described above.

Decomposition:
- Package mux_scan_pkg holds:
  - DATA_W = 16, SEL_W = 4, FRAME_LEN (16, or 17 with the feature).
  - State enum {IDLE, SHIFT, PAR}.
  - Functions start_idx(LSB_FIRST) and end_idx(LSB_FIRST).
- No sub-module: counter and FSM are too small to split. The 16:1 mux remains an external sibling instance.

Test Plan:
- Bench wiring: mux_d/mux_s feed a behavioural mux model (mux_y = mux_d[mux_s]).
- Reset then load 16'hA5C3, out_ready = 1, LSB_FIRST = 1 -> beats 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1. out_first on beat 0, out_last on beat 15, then return to IDLE.
- Same word with LSB_FIRST = 0 -> MSB-first sequence 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1; mux_s runs 15..0.
- Words 16'hFFFF then 16'h0001 with in_valid held high -> 32 consecutive valid beats with no gap; in_ready pulses only on the beat-15 handshake.
- Toggle out_ready 0/1 every cycle on 16'h8001 -> out_bit, mux_s and in_ready stay stable during stalls; bitstream is correct; frame takes 32 cycles.
- Assert rst at beat 7 of 16'h1234 -> out_valid = 0, mux_d = 0 and mux_s = 0 immediately; next word after release starts at beat 0.
- With MUX_SCAN_PARITY_EN, load 16'h0007 -> 16 data beats, then a 17th beat with out_bit = 1 and out_last = 1. Load 16'h0003 -> parity beat is 0.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// Shared types, widths and select-order helpers for mux_scan_serializer.
// Optional parity beat: define MUX_SCAN_PARITY_EN.
package mux_scan_pkg;

   localparam int DATA_W = 16;
   localparam int SEL_W  = 4;
`ifdef MUX_SCAN_PARITY_EN
   localparam int FRAME_LEN = DATA_W + 1;
`else
   localparam int FRAME_LEN = DATA_W;
`endif

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      PAR   = 2'd2
   } state_t;

   // LSB-first walks 0 -> 15, MSB-first walks 15 -> 0.
   function automatic logic [SEL_W-1:0] start_idx(input logic lsb_first);
      return {SEL_W{~lsb_first}};
   endfunction

   function automatic logic [SEL_W-1:0] end_idx(input logic lsb_first);
      return {SEL_W{lsb_first}};
   endfunction

endpackage

// File: rtl/mux_scan_serializer.sv
// Drives an external 16:1 bit mux through all selects and streams its output as framed serial beats.
// Optional trailing even-parity beat when MUX_SCAN_PARITY_EN is defined.
module mux_scan_serializer
   import mux_scan_pkg::*;
#(
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic [DATA_W-1:0] mux_d,
   output logic [SEL_W-1:0]  mux_s,
   input  logic              mux_y,
   output logic              out_valid,
   output logic              out_bit,
   output logic              out_first,
   output logic              out_last,
   input  logic              out_ready
);

   localparam logic [SEL_W-1:0] START = start_idx(LSB_FIRST);
   localparam logic [SEL_W-1:0] END   = end_idx(LSB_FIRST);

   state_t           state;
   logic             at_end;
   logic             do_load;
   logic [SEL_W-1:0] next_sel;
`ifdef MUX_SCAN_PARITY_EN
   logic             par_acc;
`endif

   assign at_end   = (mux_s == END);
   assign next_sel = LSB_FIRST ? mux_s + 4'd1 : mux_s - 4'd1;
   assign do_load  = in_valid && in_ready;

   // in_ready opens on the final accepted beat so the next word loads with no bubble.
   always_comb begin
      in_ready = 1'b0;
      unique case (state)
         IDLE:    in_ready = 1'b1;
`ifdef MUX_SCAN_PARITY_EN
         PAR:     in_ready = out_ready;
`else
         SHIFT:   in_ready = out_ready && at_end;
`endif
         default: in_ready = 1'b0;
      endcase
   end

   always_comb begin
      out_bit = 1'b0;
      if (out_valid) begin
         out_bit = mux_y;
`ifdef MUX_SCAN_PARITY_EN
         if (state == PAR) out_bit = par_acc;
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         mux_d     <= '0;
         mux_s     <= '0;
         out_valid <= 1'b0;
         out_first <= 1'b0;
         out_last  <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
         par_acc   <= 1'b0;
`endif
      end else if (do_load) begin
         state     <= SHIFT;
         mux_d     <= in_data;
         mux_s     <= START;
         out_valid <= 1'b1;
         out_first <= 1'b1;
         out_last  <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
         par_acc   <= 1'b0;
`endif
      end else begin
         unique case (state)
            SHIFT: begin
               if (out_ready) begin
                  out_first <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
                  par_acc <= par_acc ^ mux_y;
`endif
                  if (!at_end) begin
                     mux_s <= next_sel;
`ifndef MUX_SCAN_PARITY_EN
                     out_last <= (next_sel == END);
`endif
                  end else begin
`ifdef MUX_SCAN_PARITY_EN
                     state    <= PAR;
                     out_last <= 1'b1;
`else
                     state     <= IDLE;
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
`endif
                  end
               end
            end
`ifdef MUX_SCAN_PARITY_EN
            PAR: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
               end
            end
`endif
            default: ;
         endcase
      end
   end

endmodule
